// File: rtl/sfx_player.sv
// Sound-effect sequencer: plays a short fixed note sequence per effect as a
// 1-bit square wave, with busy status and a one-cycle done pulse on completion.
module sfx_player #(
  parameter int NOTE_TICKS = 2_500_000,
  parameter int GAP_TICKS  = 250_000,
  parameter int HP_SHIFT   = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       playsound,
  input  logic [1:0] soundselector,
  input  logic       mute,
  output logic       audio,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [31:0] NOTE_END = 32'(NOTE_TICKS - 1);
  localparam logic [31:0] GAP_END  = 32'(GAP_TICKS - 1);

  state_t      state, state_n;
  logic [1:0]  sel, sel_n;
  logic [1:0]  idx, idx_n;
  logic [31:0] dur_cnt, dur_cnt_n;
  logic [16:0] tone_cnt, tone_cnt_n;
  logic        phase, phase_n;
  logic        busy_n, done_n, audio_n;
  logic [16:0] rom_hp, hp_shifted, hp;
  logic        last_note;

  // Note ROM: half-periods in clk cycles; effect length is sel+1 notes.
  always_comb begin
    rom_hp = 17'd12500;
    case ({sel, idx})
      4'b00_00: rom_hp = 17'd12500;
      4'b01_00: rom_hp = 17'd18939;
      4'b01_01: rom_hp = 17'd12626;
      4'b10_00: rom_hp = 17'd56818;
      4'b10_01: rom_hp = 17'd75758;
      4'b10_10: rom_hp = 17'd113636;
      4'b11_00: rom_hp = 17'd23889;
      4'b11_01: rom_hp = 17'd18961;
      4'b11_10: rom_hp = 17'd15944;
      4'b11_11: rom_hp = 17'd11945;
      default:  rom_hp = 17'd12500;
    endcase
  end

  assign hp_shifted = rom_hp >> HP_SHIFT;
  assign hp         = (hp_shifted == 17'd0) ? 17'd1 : hp_shifted;
  assign last_note  = (idx == sel);

  always_comb begin
    state_n    = state;
    sel_n      = sel;
    idx_n      = idx;
    dur_cnt_n  = dur_cnt;
    tone_cnt_n = tone_cnt;
    phase_n    = phase;
    busy_n     = busy;
    done_n     = 1'b0;
    if (playsound) begin
      // A request always wins, including over a note end in the same cycle.
      state_n    = TONE;
      sel_n      = soundselector;
      idx_n      = 2'd0;
      dur_cnt_n  = 32'd0;
      tone_cnt_n = 17'd0;
      phase_n    = 1'b0;
      busy_n     = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          busy_n  = 1'b0;
          phase_n = 1'b0;
        end
        TONE: begin
          if (dur_cnt == NOTE_END) begin
            dur_cnt_n  = 32'd0;
            tone_cnt_n = 17'd0;
            phase_n    = 1'b0;
            if (last_note) begin
              state_n = IDLE;
              busy_n  = 1'b0;
              done_n  = 1'b1;
            end else if (GAP_TICKS > 0) begin
              state_n = GAP;
            end else begin
              idx_n = idx + 2'd1;
            end
          end else begin
            dur_cnt_n = dur_cnt + 32'd1;
            if (tone_cnt == hp - 17'd1) begin
              tone_cnt_n = 17'd0;
              phase_n    = ~phase;
            end else begin
              tone_cnt_n = tone_cnt + 17'd1;
            end
          end
        end
        GAP: begin
          phase_n = 1'b0;
          if (dur_cnt == GAP_END) begin
            state_n    = TONE;
            idx_n      = idx + 2'd1;
            dur_cnt_n  = 32'd0;
            tone_cnt_n = 17'd0;
          end else begin
            dur_cnt_n = dur_cnt + 32'd1;
          end
        end
        default: begin
          state_n = IDLE;
          busy_n  = 1'b0;
          phase_n = 1'b0;
        end
      endcase
    end
  end

  // Mute only gates the pin; the phase keeps running underneath.
  assign audio_n = phase_n & ~mute;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sel      <= 2'd0;
      idx      <= 2'd0;
      dur_cnt  <= 32'd0;
      tone_cnt <= 17'd0;
      phase    <= 1'b0;
      audio    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      sel      <= sel_n;
      idx      <= idx_n;
      dur_cnt  <= dur_cnt_n;
      tone_cnt <= tone_cnt_n;
      phase    <= phase_n;
      audio    <= audio_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_sfx_player.sv
// Directed bench for sfx_player: expected {audio,busy,done} per cycle is queued
// when a request is driven and popped one entry per clock.
module tb_sfx_player;

  localparam int N  = 100;
  localparam int G  = 10;
  localparam int HS = 8;

  logic       clk;
  logic       reset;
  logic       playsound;
  logic [1:0] soundselector;
  logic       mute;
  logic       audio;
  logic       busy;
  logic       done;

  logic [2:0] exp_q[$];
  int checks;
  int errors;

  sfx_player #(.NOTE_TICKS(N), .GAP_TICKS(G), .HP_SHIFT(HS)) dut (
    .clk           (clk),
    .reset         (reset),
    .playsound     (playsound),
    .soundselector (soundselector),
    .mute          (mute),
    .audio         (audio),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Half-periods after the sim shift, written out independently of the ROM.
  function automatic int hp_tab(input int sel, input int i);
    int t[4][4];
    t[0] = '{48, 0, 0, 0};
    t[1] = '{73, 49, 0, 0};
    t[2] = '{221, 295, 443, 0};
    t[3] = '{93, 74, 62, 46};
    return t[sel][i];
  endfunction

  // Expected {audio,busy,done} t cycles after the request edge of effect sel.
  function automatic logic [2:0] exp_at(input int sel, input int t, input logic m);
    int len, total, period, i, off;
    logic a, b, d;
    len    = sel + 1;
    period = N + G;
    total  = len * N + (len - 1) * G;
    a = 1'b0;
    b = 1'b0;
    d = 1'b0;
    if (t < total) begin
      b   = 1'b1;
      i   = t / period;
      off = t % period;
      if (off < N) a = (((off / hp_tab(sel, i)) % 2) == 1);
    end else if (t == total) begin
      d = 1'b1;
    end
    if (m) a = 1'b0;
    return {a, b, d};
  endfunction

  function automatic int total_of(input int sel);
    return (sel + 1) * N + sel * G;
  endfunction

  task automatic step(input logic ps, input logic [1:0] s, input logic m,
                      input logic rst, input string tag);
    logic [2:0] obs;
    logic [2:0] exp_v;
    playsound     = ps;
    soundselector = ps ? s : 2'($urandom_range(0, 3));
    mute          = m;
    reset         = rst;
    @(posedge clk);
    #1;
    playsound = 1'b0;
    reset     = 1'b0;
    obs       = {audio, busy, done};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s queue_empty observed=%b", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        errors++;
        $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
      end
    end
  endtask

  // Run effect sel from cycle t0 through t1 (request issued if t0 == 0).
  task automatic run_effect(input int sel, input int t0, input int t1,
                            input int mute_until, input string name);
    for (int t = t0; t <= t1; t++) begin
      exp_q.push_back(exp_at(sel, t, t <= mute_until));
      step(t == 0, 2'(sel), t <= mute_until, 1'b0, $sformatf("%s t=%0d", name, t));
    end
  endtask

  initial begin
    int rs, rs2, rp;
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    playsound     = 1'b0;
    soundselector = 2'd0;
    mute          = 1'b0;

    // Reset state, even with a request pending.
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(3'b000);
      step(k == 2, 2'd3, 1'b0, 1'b1, $sformatf("reset k=%0d", k));
    end
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(3'b000);
      step(1'b0, 2'd0, 1'b0, 1'b0, $sformatf("idle k=%0d", k));
    end

    // UI_PRESS: single note, hp 48.
    run_effect(0, 0, N + 1, -1, "ui");

    // NEXTLEVEL: two notes with a gap.
    run_effect(1, 0, total_of(1) + 1, -1, "nextlevel");

    // CELEBRATION pre-empted by CRASH at cycle 150.
    run_effect(3, 0, 149, -1, "celeb");
    run_effect(2, 0, total_of(2) + 1, -1, "crash_pre");

    // CRASH aborted by reset at cycle 50, no done afterwards.
    run_effect(2, 0, 49, -1, "crash_rst");
    exp_q.push_back(3'b000);
    step(1'b0, 2'd0, 1'b0, 1'b1, "abort_reset");
    for (int k = 0; k < 20; k++) begin
      exp_q.push_back(3'b000);
      step(1'b0, 2'd0, 1'b0, 1'b0, $sformatf("after_abort k=%0d", k));
    end

    // UI_PRESS muted for cycles 0..59.
    run_effect(0, 0, N + 1, 59, "ui_mute");

    // Request lands on the final-note edge: restart wins, no done.
    run_effect(0, 0, N - 1, -1, "ui_first");
    run_effect(0, 0, N + 1, -1, "ui_restart");

    // Random effect pre-empted at a random point by another random effect.
    rs  = $urandom_range(0, 3);
    rs2 = $urandom_range(0, 3);
    rp  = $urandom_range(1, total_of(rs) - 1);
    run_effect(rs, 0, rp - 1, -1, "rand_a");
    run_effect(rs2, 0, total_of(rs2) + 1, -1, "rand_b");

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
